// File: rtl/uart_direct_rx.sv
// uart_direct_rx: direct-pin 8N1 serial receiver feeding a first-word-fall-through
// byte FIFO that the memory controller polls and pops.
module uart_direct_rx #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overrun,
    output logic                  frame_err,
    input  logic                  clr_err
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = $clog2(DIV + 1);

    localparam logic [CW-1:0]       DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]       HALF_LAST = CW'(HALF - 1);
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    logic                  meta_q, meta_d;
    logic                  rx_s_q, rx_s_d;
    logic                  rx_prev_q, rx_prev_d;
    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            shift_q, shift_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;
    logic [7:0]            mem_q [DEPTH];

    logic push, set_ferr, do_push, do_pop, full, drop;

    // Bit-timing FSM: half-bit qualify of the start bit, then full-bit samples.
    always_comb begin
        meta_d    = rxd;
        rx_s_d    = meta_q;
        rx_prev_d = rx_s_q;
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        set_ferr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s_q) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        set_ferr = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A held-low line (break) must return high before a new start counts.
                cnt_d = '0;
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; a pop in the same cycle frees the slot for a push into a full FIFO.
    always_comb begin
        do_pop      = rd_en && (count_q != '0);
        full        = (count_q == DEPTH_CNT);
        do_push     = push && (!full || do_pop);
        drop        = push && full && !do_pop;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
        if (clr_err) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (drop)     overrun_d   = 1'b1;
        if (set_ferr) frame_err_d = 1'b1;
    end

    // State registers; synchroniser presets to the idle line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            meta_q      <= meta_d;
            rx_s_q      <= rx_s_d;
            rx_prev_q   <= rx_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Byte storage; contents are unreachable after reset because count is zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule

// File: doc/uart_direct_rx.md
Name: uart_direct_rx

Overview:
- Receiver for the board's direct serial pin (rxd), decoupled from the CPLD UART path.
- Oversamples the line, deserialises 8N1 frames and buffers bytes in a first-word-fall-through FIFO.
- Sits directly upstream of the memory controller, which polls rd_valid and pops bytes when the CPU issues a load to the serial data address.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate. DIV = CLK_FREQ/BAUD, integer truncation; 434 at defaults.
- DEPTH_LOG2, 4, FIFO depth is 2^DEPTH_LOG2 bytes (16 at defaults).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset. 0 resets, 1 runs.
- rxd  input  1  raw serial line, idle high, asynchronous to clk.
- rd_en  input  1  pop request, one byte per cycle when high.
- rd_data  output  8  FIFO head byte, valid while rd_valid=1.
- rd_valid  output  1  FIFO non-empty.
- fifo_count  output  DEPTH_LOG2+1  bytes currently buffered.
- overrun  output  1  sticky: a received byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: a stop bit sampled 0.
- clr_err  input  1  clears overrun and frame_err on the next edge.

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; pointers and count go to 0.
  - rd_valid=0, rd_data=0x00, fifo_count=0, overrun=0, frame_err=0.
  - Synchroniser flops preset to 1.
- rxd passes through a 2-flop synchroniser, giving rx_s. All sampling uses rx_s; input-to-rx_s latency is 2 cycles.
- Baud counter counts 0..DIV-1 and restarts at every state entry.
- FSM states and transitions:
  - IDLE: a 1->0 transition on rx_s moves to START.
  - START: wait DIV/2 cycles (integer), sample rx_s. If 1, it was a false start; go to IDLE. If 0, go to DATA with bit index 0.
  - DATA: wait DIV cycles, sample rx_s into shift register bit [idx] (LSB first). After idx 7 go to STOP.
  - STOP: wait DIV cycles, sample rx_s. If 1, push the byte and go to IDLE. If 0, set frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break condition from retriggering reception.
- Push takes effect on the stop-sample edge. rd_valid/fifo_count reflect it on the following cycle (count updates registered).
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit pointers that wrap modulo depth.
  - rd_data = mem[rd_ptr], first-word fall-through: the new head appears the cycle after a pop.
- Pop when empty: ignored, no pointer or count change.
- Push when full and no pop in the same cycle: byte dropped, overrun set, FIFO contents unchanged.
- Push and pop in the same cycle: both happen and count is unchanged. This includes the full case, where the push is accepted and overrun is not set.
- Error flags:
  - clr_err and a new error event in the same cycle: the set wins and the flag stays 1.
  - Flags never clear themselves.
- Reset mid-frame discards the partial byte and all buffered bytes. The next complete frame after release is received normally.
- fifo_count range is 0..2^DEPTH_LOG2. The full flag is count==depth, not a pointer compare.

Test Plan:
- Default params, drive the 0x55 frame at 434 cycles/bit -> rd_valid rises 1 cycle after the stop-bit mid-sample, rd_data=0x55, fifo_count=1; pulse rd_en 1 cycle -> rd_valid=0, count=0.
- Glitch: rxd low for 100 cycles, then high -> START rejects it, count stays 0, no flags set.
- Send 0xA3 with stop bit driven 0 for 2000 cycles -> frame_err=1, count=0; FSM stays in WAIT_IDLE until rxd=1; then 0x3C frame received correctly; pulse clr_err -> frame_err=0.
- Send bytes 0x00..0x10 (17 frames) with no pops -> count=16, overrun=1; popping 16 times yields 0x00..0x0F in order; pointers wrap correctly on a further 3 push/pop rounds.
- FIFO full (16 bytes), assert rd_en on exactly the stop-sample cycle of a 17th byte 0x99 -> count stays 16, overrun stays 0, 0x99 read last.
- Assert rst=0 during DATA bit 3 of 0x7E, release, then send 0x81 -> only 0x81 in FIFO, count=1, flags 0.
